// File: rtl/imem_sync.sv
// imem_sync: clocked instruction memory for the fetch stage.
// Registered read, optional wait states, req/ready + rvalid/rready.
module imem_sync #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "file_test.txt"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [31:0]       addr,
  output logic              ready,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic [IDX_W-1:0]  a_idx;
  logic              a_bad;
  logic              load_rd;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_bad;
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_ok;
  logic              unused_lsb;

  assign accept     = req && ready;
  assign a_idx      = addr[IDX_W+1:2];
  assign a_bad      = (addr[1:0] != 2'b00) ||
                      (addr[31:IDX_W+2] != '0);
  assign ld_idx     = ld_addr[IDX_W+1:2];
  assign ld_ok      = (ld_addr[31:IDX_W+2] == '0);
  assign unused_lsb = ^ld_addr[1:0];

  // Load port: ignores reset, drops out-of-range addresses.
  always_ff @(posedge clk) begin
    if (ld_we && ld_ok) mem[ld_idx] <= ld_wdata;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state; memory is sampled on the edge entering RESP,
  // so a load write on that same edge is not yet visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    load_rd = 1'b0;
    rd_idx  = idx_q;
    rd_bad  = bad_q;
    if (accept) begin
      idx_d = a_idx;
      bad_d = a_bad;
      if (WAIT_STATES == 0) begin
        state_d = S_RESP;
        load_rd = 1'b1;
        rd_idx  = a_idx;
        rd_bad  = a_bad;
      end else begin
        state_d = S_WAIT;
        cnt_d   = WS_M1;
      end
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = S_RESP;
            load_rd = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rready) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
    if (load_rd) begin
      rdata_d = rd_bad ? '0 : mem[rd_idx];
      err_d   = rd_bad;
    end
  end

  // Outputs; ready is held low while reset is asserted.
  always_comb begin
    ready  = !rst &&
             ((state_q == S_IDLE) ||
              ((state_q == S_RESP) && rready));
    rvalid = (state_q == S_RESP);
    rdata  = rdata_q;
    err    = err_q;
  end

endmodule
